icache_ctrl: RTL and testbench

- Direct-mapped instruction cache controller between the fetch stage and the instruction backing memory at 0xBFC00000–0xBFC00FFF.
- Serves hits combinationally from flop-based tag/data arrays.
- On a miss, stalls fetch and sequences a multi-beat line refill over a valid/ack word port.
- Keeps hit and miss performance counters.

---
 rtl/icache_ctrl.sv | 126 ++++++++++++
 tb/tb_icache_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: combinational hits from flop arrays,
// multi-beat line refill over a valid/ack word port, hit/miss counters.
`timescale 1ns/1ps
module icache_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SETS       = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  stall,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic                  fsm_state
);

  localparam int WB   = $clog2(WORDS_PER_LINE);
  localparam int OFF  = WB + 2;
  localparam int IDX  = $clog2(NUM_SETS);
  localparam int TAGW = ADDR_WIDTH - OFF - IDX;

  typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

  // Memory port handshake: mem_req/mem_addr are held stable from the cycle mem_req
  // rises until the cycle mem_ack=1 is sampled at a rising edge; that edge completes
  // the beat. mem_ack is ignored while mem_req=0.
  state_t                 state;
  logic [NUM_SETS-1:0]    valid;
  logic [TAGW-1:0]        tags [NUM_SETS];
  logic [DATA_WIDTH-1:0]  data [NUM_SETS*WORDS_PER_LINE];
  logic [IDX-1:0]         fill_idx;
  logic [TAGW-1:0]        fill_tag;
  logic [WB-1:0]          beat;
  logic [WB-1:0]          beat_nxt;

  logic [TAGW-1:0]        pc_tag;
  logic [IDX-1:0]         pc_idx;
  logic [WB-1:0]          pc_word;
  logic                   tag_match;
  logic                   lookup_hit;
  logic                   lookup_miss;
  logic                   unused_pc_bits;

  assign pc_tag         = pc[ADDR_WIDTH-1:OFF+IDX];
  assign pc_idx         = pc[OFF+IDX-1:OFF];
  assign pc_word        = pc[OFF-1:2];
  assign unused_pc_bits = ^pc[1:0];
  assign beat_nxt       = beat + 1'b1;

  assign tag_match   = valid[pc_idx] & (tags[pc_idx] == pc_tag);
  assign lookup_hit  = ~rst & (state == IDLE) & fetch_req & tag_match;
  assign lookup_miss = ~rst & (state == IDLE) & fetch_req & ~tag_match;

  assign instr_valid = lookup_hit;
  assign instr       = lookup_hit ? data[{pc_idx, pc_word}] : '0;
  assign stall       = ~rst & ((state == REFILL) | lookup_miss);
  assign fsm_state   = (state == REFILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      beat       <= '0;
      fill_idx   <= '0;
      fill_tag   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookup_hit) hit_count <= hit_count + 32'd1;
      case (state)
        IDLE: begin
          // A flush coinciding with a miss wins; the miss is re-evaluated next cycle.
          if (flush) begin
            valid <= '0;
          end else if (lookup_miss) begin
            state      <= REFILL;
            fill_idx   <= pc_idx;
            fill_tag   <= pc_tag;
            beat       <= '0;
            mem_req    <= 1'b1;
            mem_addr   <= {pc_tag, pc_idx, {OFF{1'b0}}};
            miss_count <= miss_count + 32'd1;
          end
        end
        REFILL: begin
          if (flush) begin
            valid   <= '0;
            state   <= IDLE;
            mem_req <= 1'b0;
          end else if (mem_ack) begin
            if (&beat) begin
              valid[fill_idx] <= 1'b1;
              state           <= IDLE;
              mem_req         <= 1'b0;
            end else begin
              beat     <= beat_nxt;
              mem_addr <= {fill_tag, fill_idx, beat_nxt, 2'b00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Arrays carry no reset; a line only becomes usable once its valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && state == REFILL && mem_ack) begin
      data[{fill_idx, beat}] <= mem_rdata;
      if (&beat && !flush) tags[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios then random fetches,
// compared against an array-based cache model driven by the address-split rules.
`timescale 1ns/1ps
module tb_icache_ctrl;
  localparam int NS  = 16;
  localparam int WPL = 4;
  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst, fetch_req, flush, mem_ack;
  logic [31:0] pc, mem_rdata;
  logic [31:0] instr, mem_addr, hit_count, miss_count;
  logic        instr_valid, stall, mem_req, fsm_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  icache_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SETS(NS), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc(pc), .flush(flush),
    .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count), .fsm_state(fsm_state)
  );

  // reference model
  bit          ref_valid [NS];
  logic [23:0] ref_tag   [NS];
  logic [31:0] ref_data  [NS*WPL];
  int unsigned ref_hits, ref_misses;

  int          mem_gen = 0;
  int          cur_lat = 1;
  int          ab_beat = -1;
  int          ab_kind = 0;
  int          bp_beat = -1;
  logic [31:0] bp_pc   = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] gen;
    gen = mem_gen;
    return 32'h13 + ((a - BASE) >> 2) + (gen << 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) ref_valid[i] = 1'b0;
  endtask

  // Check the current-cycle lookup against the model; returns miss=1 on a miss.
  task automatic lookup(output bit miss);
    logic [3:0] i;
    logic [5:0] di;
    i  = pc[7:4];
    di = {pc[7:4], pc[3:2]};
    chk("hit_count", hit_count, ref_hits);
    chk("miss_count", miss_count, ref_misses);
    miss = 1'b0;
    if (!fetch_req) begin
      chk("idle_valid", {31'b0, instr_valid}, 32'd0);
      chk("idle_stall", {31'b0, stall}, 32'd0);
    end else if (ref_valid[i] && ref_tag[i] == pc[31:8]) begin
      chk("hit_valid", {31'b0, instr_valid}, 32'd1);
      chk("hit_instr", instr, ref_data[di]);
      chk("hit_stall", {31'b0, stall}, 32'd0);
      chk("hit_memreq", {31'b0, mem_req}, 32'd0);
      ref_hits++;
    end else begin
      chk("miss_stall", {31'b0, stall}, 32'd1);
      chk("miss_valid", {31'b0, instr_valid}, 32'd0);
      miss = 1'b1;
    end
  endtask

  // Acts as backing memory for one refill, entered in the miss cycle (IDLE).
  task automatic serve();
    logic [31:0] base;
    int          lat_b;
    int          cycles;
    bit          aborted;
    base    = {pc[31:4], 4'b0};
    cycles  = 0;
    aborted = 1'b0;
    ref_misses++;
    for (int b = 0; b < WPL && !aborted; b++) begin
      lat_b = (b == bp_beat) ? 5 : cur_lat;
      for (int w = 0; w <= lat_b; w++) begin
        @(negedge clk);
        mem_ack   = (w == lat_b);
        mem_rdata = mem_word(base + 4 * b);
        if (b == bp_beat && w == 1) pc = bp_pc;
        if (b == ab_beat && w == lat_b) begin
          if (ab_kind == 0) flush = 1'b1;
          else rst = 1'b1;
        end
        #1;
        if (rst) begin
          chk("rst_stall", {31'b0, stall}, 32'd0);
          chk("rst_valid", {31'b0, instr_valid}, 32'd0);
          chk("rst_instr", instr, 32'd0);
        end else begin
          chk("refill_req", {31'b0, mem_req}, 32'd1);
          chk("refill_addr", mem_addr, base + 4 * b);
          chk("refill_stall", {31'b0, stall}, 32'd1);
          chk("refill_valid", {31'b0, instr_valid}, 32'd0);
          chk("refill_state", {31'b0, fsm_state}, 32'd1);
        end
        cycles++;
      end
      if (b == ab_beat) aborted = 1'b1;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    if (aborted) begin
      if (rst) begin
        ref_hits   = 0;
        ref_misses = 0;
      end
      flush = 1'b0;
      rst   = 1'b0;
      model_clear();
      #1;
      if (ab_kind == 1) chk("rst_addr", mem_addr, 32'd0);
      ab_beat = -1;
    end else begin
      ref_valid[base[7:4]] = 1'b1;
      ref_tag[base[7:4]]   = base[31:8];
      for (int b = 0; b < WPL; b++) ref_data[{base[7:4], 2'(b)}] = mem_word(base + 4 * b);
      #1;
      chk("refill_cycles", cycles, WPL * (cur_lat + 1) + ((bp_beat >= 0) ? (5 - cur_lat) : 0));
      bp_beat = -1;
    end
    chk("done_memreq", {31'b0, mem_req}, 32'd0);
    chk("done_state", {31'b0, fsm_state}, 32'd0);
  endtask

  task automatic resolve();
    bit miss;
    int guard;
    guard = 0;
    lookup(miss);
    while (miss && guard < 4) begin
      serve();
      lookup(miss);
      guard++;
    end
    chk("fetch_resolved", {31'b0, miss}, 32'd0);
  endtask

  task automatic do_fetch(input logic [31:0] a, input int lat);
    @(negedge clk);
    fetch_req = 1'b1;
    pc        = a;
    cur_lat   = lat;
    #1;
    resolve();
  endtask

  task automatic idle_cycle();
    bit miss;
    @(negedge clk);
    fetch_req = 1'b0;
    #1;
    lookup(miss);
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    pc = '0; mem_rdata = '0;
    ref_hits = 0; ref_misses = 0;
    model_clear();
    repeat (3) @(negedge clk);
    fetch_req = 1'b1; pc = BASE;
    #1;
    chk("rst_hold_stall", {31'b0, stall}, 32'd0);
    chk("rst_hold_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_hold_instr", instr, 32'd0);
    @(negedge clk);
    rst = 1'b0; fetch_req = 1'b0;
    #1;
    chk("reset_memreq", {31'b0, mem_req}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_hits", hit_count, 32'd0);
    chk("reset_misses", miss_count, 32'd0);
    chk("reset_state", {31'b0, fsm_state}, 32'd0);

    // cold miss, then hit on the last word of the line
    do_fetch(BASE, 1);
    chk("cold_instr", instr, 32'h00000013);
    do_fetch(BASE + 32'hC, 1);
    chk("line_hit_instr", instr, 32'h00000016);
    idle_cycle();

    // conflict eviction at index 0 with changed memory contents
    mem_gen = 1;
    do_fetch(BASE + 32'h100, 1);
    do_fetch(BASE, 1);
    chk("reload_instr", instr, 32'h00010013);
    chk("conflict_misses", miss_count, 32'd3);

    // flush at beat 2, and flush colliding with the final ack
    ab_beat = 2; ab_kind = 0;
    do_fetch(BASE + 32'h20, 0);
    ab_beat = 3; ab_kind = 0;
    do_fetch(BASE + 32'h30, 1);

    // flush together with a miss in IDLE: no refill started, no miss counted
    @(negedge clk);
    fetch_req = 1'b1; pc = BASE + 32'h50; flush = 1'b1;
    #1;
    chk("flush_miss_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    #1;
    chk("flush_miss_state", {31'b0, fsm_state}, 32'd0);
    chk("flush_miss_memreq", {31'b0, mem_req}, 32'd0);
    resolve();

    // backpressure on beat 1 with pc moving during the wait
    bp_beat = 1; bp_pc = BASE + 32'h40;
    do_fetch(BASE, 1);
    do_fetch(BASE + 32'h4, 0);

    // reset in the middle of a refill
    ab_beat = 1; ab_kind = 1;
    do_fetch(BASE + 32'h60, 1);

    // random fetch traffic
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = BASE | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) | ($urandom_range(0, 3) << 2);
      mem_gen = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) idle_cycle();
      do_fetch(a, $urandom_range(0, 2));
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
